// File: rtl/msk_encode_stage_if.sv
// Handshake bundle for the masking encoder: unmasked input, fresh randomness, and the shared output.
// The environment side is the master; the encoder stage is the slave.
interface msk_encode_stage_if #(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 1
);
    // Randomness is absent when d == 1; a 1-bit unused bus keeps the width legal.
    localparam int unsigned RW = (d > 1) ? count * (d - 1) : 1;
    localparam int unsigned SW = count * d;

    logic [count-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [RW-1:0]    rnd;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [SW-1:0]    out_sh;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ready, out_sh, out_valid
    );

    modport slave (
        input  in_data, in_valid, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ready, out_sh, out_valid
    );
endinterface

// File: rtl/msk_encode_stage.sv
// Registered Boolean masking encoder with a 2-entry elastic skid buffer.
// Share j of bit i lives at out_sh[i*d+j]; only shares are ever stored.
module msk_encode_stage #(
    parameter int unsigned d     = 2,
    parameter int unsigned count = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    msk_encode_stage_if.slave    bus
);
    localparam int unsigned SW      = count * d;
    localparam bit          HAS_RND = (d > 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Share registers must survive synthesis as distinct flops.
    (* keep = "true" *) logic [SW-1:0] main_q;
    (* keep = "true" *) logic [SW-1:0] skid_q;
    logic [SW-1:0] main_d, skid_d;

    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;

    logic [SW-1:0] enc_c;
    logic          mix_c;
    logic          rnd_ok_c;
    logic          acc_c;

    // Combinational encode: share 0 absorbs the data bit and all random shares.
    always_comb begin
        enc_c = '0;
        mix_c = 1'b0;
        for (int unsigned i = 0; i < count; i++) begin
            mix_c = bus.in_data[i];
            for (int unsigned j = 1; j < d; j++) begin
                enc_c[i*d + j] = bus.rnd[i*(d-1) + j - 1];
                mix_c          = mix_c ^ bus.rnd[i*(d-1) + j - 1];
            end
            enc_c[i*d] = mix_c;
        end
    end

    assign rnd_ok_c = HAS_RND ? bus.rnd_valid : 1'b1;
    assign acc_c    = bus.in_valid & in_ready_q & rnd_ok_c;

    // Next state and buffer moves keyed on occupancy.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (acc_c) begin
                    state_d = ONE;
                    main_d  = enc_c;
                end
            end
            ONE: begin
                if (acc_c && !bus.out_ready) begin
                    state_d = FULL;
                    skid_d  = enc_c;
                end else if (acc_c) begin
                    main_d = enc_c;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Randomness is consumed exactly on accepted words; never when d == 1.
    assign bus.rnd_ready = HAS_RND & acc_c;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sh    = main_q;
endmodule

// File: tb/tb_msk_encode_stage.sv
// Directed bench for msk_encode_stage: d=2/count=4 instance plus a d=1/count=2 instance.
module tb_msk_encode_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    msk_encode_stage_if #(.d(2), .count(4)) bus2 ();
    msk_encode_stage_if #(.d(1), .count(2)) bus1 ();

    msk_encode_stage #(.d(2), .count(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    msk_encode_stage #(.d(1), .count(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [3:0] in_data;
        logic [3:0] rnd;
        logic [7:0] exp_sh;
    } vec_t;

    vec_t vecs [8];
    int   tests   = 0;
    int   fails   = 0;
    int   acc_cnt = 0;
    int   acc_base;
    logic rnd1_seen = 1'b0;

    always @(posedge clk) begin
        if (bus2.rnd_ready === 1'b1) acc_cnt <= acc_cnt + 1;
        if (bus1.rnd_ready !== 1'b0) rnd1_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] recomb(input logic [7:0] sh);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = sh[2*i] ^ sh[2*i+1];
        return r;
    endfunction

    task automatic drive2(input vec_t v, input logic rv);
        bus2.in_data   = v.in_data;
        bus2.rnd       = v.rnd;
        bus2.rnd_valid = rv;
        bus2.in_valid  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // out_sh = {r3,x3,r2,x2,r1,x1,r0,x0} with x = in_data ^ rnd
        vecs[0] = '{4'b1010, 4'b0110, 8'h78};
        vecs[1] = '{4'b0000, 4'b0000, 8'h00};
        vecs[2] = '{4'b1111, 4'b0000, 8'h55};
        vecs[3] = '{4'b0000, 4'b1111, 8'hFF};
        vecs[4] = '{4'b1111, 4'b1111, 8'hAA};
        vecs[5] = '{4'b0101, 4'b0011, 8'h1E};
        vecs[6] = '{4'b1001, 4'b1100, 8'hB1};
        vecs[7] = '{4'b0011, 4'b1010, 8'hC9};

        rst_n          = 1'b0;
        drive2(vecs[0], 1'b1);
        bus2.out_ready = 1'b1;
        bus1.in_data   = 2'b00;
        bus1.in_valid  = 1'b0;
        bus1.rnd       = 1'b0;
        bus1.rnd_valid = 1'b0;
        bus1.out_ready = 1'b1;

        // Reset state, with valid inputs presented during reset
        #12;
        check("rst_in_ready",  32'(bus2.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus2.out_valid), 32'd0);
        check("rst_out_sh",    32'(bus2.out_sh),    32'd0);
        check("rst_rnd_ready", 32'(bus2.rnd_ready), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus2.in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus2.in_ready), 32'd1);

        // Single word: latency 1, one rnd_ready pulse
        @(negedge clk);
        acc_base = acc_cnt;
        drive2(vecs[0], 1'b1);
        #1 check("single_rnd_ready", 32'(bus2.rnd_ready), 32'd1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("single_out_valid", 32'(bus2.out_valid), 32'd1);
        check("single_out_sh",    32'(bus2.out_sh),    32'h78);
        check("single_recomb",    32'(recomb(bus2.out_sh)), 32'(4'b1010));
        @(negedge clk);
        check("single_drain",     32'(bus2.out_valid), 32'd0);
        check("single_acc_count", 32'(acc_cnt - acc_base), 32'd1);

        // Back-to-back stream of 8 words
        @(negedge clk);
        acc_base = acc_cnt;
        drive2(vecs[0], 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("stream_valid%0d", k), 32'(bus2.out_valid), 32'd1);
            check($sformatf("stream_sh%0d", k), 32'(bus2.out_sh), 32'(vecs[k].exp_sh));
            check($sformatf("stream_recomb%0d", k), 32'(recomb(bus2.out_sh)), 32'(vecs[k].in_data));
            if (k < 7) drive2(vecs[k+1], 1'b1);
            else bus2.in_valid = 1'b0;
        end
        @(negedge clk);
        check("stream_drain", 32'(bus2.out_valid), 32'd0);
        check("stream_acc_count", 32'(acc_cnt - acc_base), 32'd8);

        // Fill to FULL with out_ready low; third word stalls
        bus2.out_ready = 1'b0;
        acc_base = acc_cnt;
        drive2(vecs[1], 1'b1);
        @(negedge clk);
        drive2(vecs[2], 1'b1);
        @(negedge clk);
        drive2(vecs[3], 1'b1);
        check("full_in_ready", 32'(bus2.in_ready), 32'd0);
        check("full_out_sh",   32'(bus2.out_sh),   32'(vecs[1].exp_sh));
        #1 check("full_rnd_ready", 32'(bus2.rnd_ready), 32'd0);
        @(negedge clk);
        check("full_hold_sh",    32'(bus2.out_sh),   32'(vecs[1].exp_sh));
        check("full_hold_ready", 32'(bus2.in_ready), 32'd0);
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        @(negedge clk);
        check("drain1_valid", 32'(bus2.out_valid), 32'd1);
        check("drain1_sh",    32'(bus2.out_sh),    32'(vecs[2].exp_sh));
        check("drain1_ready", 32'(bus2.in_ready),  32'd1);
        @(negedge clk);
        check("drain2_valid", 32'(bus2.out_valid), 32'd0);
        check("full_acc_count", 32'(acc_cnt - acc_base), 32'd2);

        // in_valid without fresh randomness: no accept for 3 cycles
        drive2(vecs[4], 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("rstall_rnd_ready%0d", k), 32'(bus2.rnd_ready), 32'd0);
            @(negedge clk);
            check($sformatf("rstall_out_valid%0d", k), 32'(bus2.out_valid), 32'd0);
            check($sformatf("rstall_in_ready%0d", k),  32'(bus2.in_ready),  32'd1);
        end
        bus2.rnd_valid = 1'b1;
        #1 check("rstall_release_rnd_ready", 32'(bus2.rnd_ready), 32'd1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("rstall_out_valid", 32'(bus2.out_valid), 32'd1);
        check("rstall_out_sh",    32'(bus2.out_sh),    32'(vecs[4].exp_sh));
        @(negedge clk);

        // Asynchronous reset while FULL; buffered words are discarded
        bus2.out_ready = 1'b0;
        drive2(vecs[5], 1'b1);
        @(negedge clk);
        drive2(vecs[6], 1'b1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("arst_pre_full", 32'(bus2.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus2.out_valid), 32'd0);
        check("arst_out_sh",    32'(bus2.out_sh),    32'd0);
        check("arst_in_ready",  32'(bus2.in_ready),  32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        check("arst_release_ready", 32'(bus2.in_ready), 32'd1);
        @(negedge clk);
        drive2(vecs[7], 1'b1);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("arst_first_valid", 32'(bus2.out_valid), 32'd1);
        check("arst_first_sh",    32'(bus2.out_sh),    32'(vecs[7].exp_sh));
        @(negedge clk);
        check("arst_no_stale", 32'(bus2.out_valid), 32'd0);

        // d=1: share equals data, rnd ignored, rnd_valid low is fine
        bus1.in_data   = 2'b01;
        bus1.rnd       = 1'b1;
        bus1.in_valid  = 1'b1;
        @(negedge clk);
        check("d1_valid0", 32'(bus1.out_valid), 32'd1);
        check("d1_sh0",    32'(bus1.out_sh),    32'(2'b01));
        bus1.in_data = 2'b10;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("d1_sh1",    32'(bus1.out_sh),    32'(2'b10));
        @(negedge clk);
        check("d1_drain",  32'(bus1.out_valid), 32'd0);
        check("d1_rnd_ready_never", 32'(rnd1_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/msk_encode_stage.md
Name: msk_encode_stage

Overview:
- Registered masking encoder that sits directly upstream of the masked NOT/AND layer.
- Converts unmasked input bits plus fresh randomness into d-share Boolean sharings in the codebase share layout: share j of bit i is at index i*d+j.
- Elastic valid/ready stage with a 2-entry skid buffer, so the masked datapath can stall without dropping or recombining shares.
- Fresh randomness is consumed only on accepted transfers.

Parameters:
- d, 2, number of shares per bit (d >= 1).
- count, 1, number of bits encoded per transfer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  count  unmasked bits to encode.
- in_valid  input  1  in_data valid.
- in_ready  output  1  stage can accept in_data this cycle.
- rnd  input  count*(d-1)  fresh randomness, bit i share j (j>=1) at index i*(d-1)+(j-1); unused when d=1.
- rnd_valid  input  1  rnd is fresh this cycle.
- rnd_ready  output  1  rnd consumed this cycle.
- out_sh  output  count*d  registered sharing.
- out_valid  output  1  out_sh valid.
- out_ready  input  1  downstream accepts out_sh.

Behaviour:
- Encoding per bit i:
  - out share j = rnd bit (i, j) for j = 1..d-1.
  - out share 0 = in_data[i] XOR all rnd bits (i, 1..d-1).
  - d = 1: out share 0 = in_data[i]; rnd ignored; rnd_ready held 0; rnd_valid treated as 1.
- Encoding is computed combinationally and stored into the buffer. Only shares are stored; the unmasked value is never registered.
- Accept condition: acc = in_valid & in_ready & rnd_ok, where rnd_ok = rnd_valid (or 1 when d = 1).
- rnd_ready = acc, so randomness is consumed exactly once per accepted word and never reused.
- Output handshake: a word leaves on out_valid & out_ready.
- FSM, based on buffer occupancy:
  - EMPTY: in_ready=1, out_valid=0.
    - acc -> ONE.
  - ONE: in_ready=1, out_valid=1, out_sh=main register.
    - acc & ~out_ready -> FULL; new word goes to the skid register.
    - acc & out_ready -> ONE; main register reloads with the new word.
    - ~acc & out_ready -> EMPTY.
    - otherwise stay in ONE.
  - FULL: in_ready=0, out_valid=1, out_sh=main register.
    - out_ready -> ONE; skid register moves to main.
  - in_ready is a registered function of state only, with no combinational path from out_ready.
- Latency: 1 cycle from acc to out_valid when EMPTY. Sustained throughput is 1 word/cycle when out_ready=1 and rnd_valid=1.
- in_valid=1 with rnd_valid=0: no accept, in_ready unchanged, buffer unchanged. The upstream word must be held stable.
- Ordering is strict FIFO; words are never dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, out_sh is held stable.
- Reset (any time, including mid-transfer):
  - state EMPTY, out_valid=0, out_sh all 0, rnd_ready=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first clock edge after release.
  - Buffered words are discarded.
- Every share register gets its own flop with no shared logic across shares. Use the same keep attributes as the other masked cells so synthesis cannot merge shares.

Test Plan:
- d=2, count=4; reset, then in_data=4'b1010, rnd=4'b0110, both valid, out_ready=1 -> one cycle later out_valid=1, share1 bits=0110, share0 bits=1100, XOR of shares=1010; rnd_ready pulsed once.
- Back-to-back stream of 8 words, rnd_valid=1, out_ready=1 -> 8 outputs on consecutive cycles, in order, every recombination correct.
- Two words accepted while out_ready=0 -> state FULL, in_ready=0, third word stalls. Release out_ready for 2 cycles -> both words emerge in order and in_ready returns to 1.
- in_valid=1 with rnd_valid=0 for 3 cycles -> no accept, rnd_ready=0, out_valid stays 0. Raise rnd_valid -> accepted next edge.
- d=1, count=2, in_data=2'b01 -> out_sh=2'b01, rnd_ready constantly 0.
- Assert rst_n low asynchronously while FULL -> out_valid and out_sh go to 0 immediately. After release, the first new word is the first output.
